// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end. Owns the fetch PC, issues one
// instruction-bus request at a time and buffers returned words, tagged with
// their PC, in a small FIFO drained by decode. Redirects flush the FIFO and
// cancel any in-flight fetch by discarding its returning data.

package ifetch_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_e;

endpackage

module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Control state
    fetch_state_e  state_q,   state_d;
    logic [31:0]   pc_q,      pc_d;
    logic [31:0]   req_pc_q,  req_pc_d;
    logic          discard_q, discard_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [CW-1:0] count_q,   count_d;

    // FIFO storage: {pc, inst} per entry, not reset (validity comes from count)
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   head;

    // Handshake decode
    logic          completion;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_after;
    logic          has_room;
    logic          start_fetch;

    // Decode bus completion, FIFO push/pop and capacity for the next fetch
    always_comb begin
        completion  = ((state_q == S_REQ) && iresp.addr_ok && iresp.data_ok) ||
                      ((state_q == S_WAIT) && iresp.data_ok);
        // Data returning in a redirect cycle belongs to the old stream.
        push        = completion && !discard_q && !redirect_valid;
        pop         = (count_q != '0) && out_ready && !redirect_valid;
        // Capacity counts the entry pushed this cycle so the FIFO never overflows.
        count_after = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        has_room    = (count_after < DEPTH_C);
    end

    // Fetch FSM next-state, PC and discard tracking
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        start_fetch = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!redirect_valid && has_room) begin
                    start_fetch = 1'b1;
                end
            end
            S_REQ: begin
                if (iresp.addr_ok) begin
                    if (iresp.data_ok) begin
                        discard_d = 1'b0;
                        if (!redirect_valid && has_room) begin
                            start_fetch = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (iresp.data_ok) begin
                    discard_d = 1'b0;
                    if (!redirect_valid && has_room) begin
                        start_fetch = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_fetch) begin
            state_d  = S_REQ;
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end

        // A redirect never touches req_pc: a posted request must keep its
        // address until addr_ok, and its data is then dropped via discard.
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (!completion && (state_q != S_IDLE)) begin
                discard_d = 1'b1;
            end
        end
    end

    // FIFO pointer and occupancy update; a redirect empties the queue
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
        count_d  = count_after;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            discard_q <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage write: tag the returned word with its request PC
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_pc_q, iresp.data};
        end
    end

    // Bus request and decode-facing outputs; head fields read as zero when empty
    always_comb begin
        ireq.valid = (state_q == S_REQ);
        ireq.addr  = req_pc_q;
        head       = mem_q[rd_ptr_q];
        out_valid  = (count_q != '0);
        out_pc     = out_valid ? head[63:32] : 32'd0;
        out_inst   = out_valid ? head[31:0]  : 32'd0;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: drives the instruction bus by hand cycle
// by cycle and compares outputs against hand-computed values. The bus always
// returns the inverted request address as the instruction word.

module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk;
    logic        resetn;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    logic        bus_addr_ok;
    logic        bus_data_ok;

    int n_checks;
    int n_errors;

    assign iresp = {bus_addr_ok, bus_data_ok, ireq.addr ^ 32'hffff_ffff};

    ifetch_queue #(
        .RESET_PC (RST_PC),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of next cycle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset, check reset values, release in the middle of cycle 0.
    task automatic do_reset();
        resetn         = 1'b0;
        bus_addr_ok    = 1'b0;
        bus_data_ok    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
        chk("rst_ireq_addr",  64'(ireq.addr),  64'(RST_PC));
        chk("rst_out_valid",  64'(out_valid),  64'd0);
        chk("rst_out_pc",     64'(out_pc),     64'd0);
        chk("rst_out_inst",   64'(out_inst),   64'd0);
        chk("rst_count",      64'(dut.count_q), 64'd0);
        resetn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // ---- Zero-wait bus with draining decode: one instruction per cycle
        do_reset();
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        out_ready   = 1'b1;
        tick(); // cycle 1
        chk("t1_c1_valid", 64'(ireq.valid), 64'd1);
        chk("t1_c1_addr",  64'(ireq.addr),  64'(RST_PC));
        chk("t1_c1_ovld",  64'(out_valid),  64'd0);
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk("t1_ovld", 64'(out_valid), 64'd1);
            chk("t1_pc",   64'(out_pc),   64'(RST_PC + 32'(4 * (k - 2))));
            chk("t1_inst", 64'(out_inst), 64'((RST_PC + 32'(4 * (k - 2))) ^ 32'hffff_ffff));
        end

        // ---- Decode stalled: exactly four pushes, then fetch stops
        do_reset();
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        out_ready   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t2_fill_valid", 64'(ireq.valid), 64'd1);
            chk("t2_fill_addr",  64'(ireq.addr),  64'(RST_PC + 32'(4 * (k - 1))));
        end
        for (int k = 5; k <= 8; k++) begin
            tick();
            chk("t2_full_valid", 64'(ireq.valid),   64'd0);
            chk("t2_full_count", 64'(dut.count_q),  64'd4);
        end
        chk("t2_head_pc",   64'(out_pc),   64'(RST_PC));
        chk("t2_head_inst", 64'(out_inst), 64'(RST_PC ^ 32'hffff_ffff));
        out_ready = 1'b1;
        tick(); // cycle 9
        chk("t2_resume_valid", 64'(ireq.valid),  64'd1);
        chk("t2_resume_addr",  64'(ireq.addr),   64'h0000_0000_bfc0_0010);
        chk("t2_resume_pc",    64'(out_pc),      64'h0000_0000_bfc0_0004);
        chk("t2_resume_count", 64'(dut.count_q), 64'd3);
        tick(); // cycle 10
        chk("t2_c10_addr",  64'(ireq.addr),   64'h0000_0000_bfc0_0014);
        chk("t2_c10_pc",    64'(out_pc),      64'h0000_0000_bfc0_0008);
        chk("t2_c10_count", 64'(dut.count_q), 64'd3);

        // ---- Slow bus: addr_ok in cycle 3, data_ok in cycle 6
        do_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t3_req_valid", 64'(ireq.valid), 64'd1);
            chk("t3_req_addr",  64'(ireq.addr),  64'(RST_PC));
        end
        bus_addr_ok = 1'b1;
        for (int k = 4; k <= 6; k++) begin
            tick();
            bus_addr_ok = 1'b0;
            chk("t3_wait_state", 64'(dut.state_q), 64'(S_WAIT));
            chk("t3_wait_valid", 64'(ireq.valid),  64'd0);
            chk("t3_wait_ovld",  64'(out_valid),   64'd0);
        end
        bus_data_ok = 1'b1;
        tick(); // cycle 7
        bus_data_ok = 1'b0;
        chk("t3_c7_ovld",  64'(out_valid), 64'd1);
        chk("t3_c7_pc",    64'(out_pc),    64'(RST_PC));
        chk("t3_c7_inst",  64'(out_inst),  64'h0000_0000_403f_ffff);
        chk("t3_c7_addr",  64'(ireq.addr), 64'h0000_0000_bfc0_0004);

        // ---- Redirect while waiting for data: returned word is dropped
        do_reset();
        out_ready   = 1'b1;
        tick(); // cycle 1
        bus_addr_ok = 1'b1;
        tick(); // cycle 2 (WAIT)
        bus_addr_ok    = 1'b0;
        chk("t4_c2_state", 64'(dut.state_q), 64'(S_WAIT));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        tick(); // cycle 3
        redirect_valid = 1'b0;
        chk("t4_c3_state", 64'(dut.state_q), 64'(S_WAIT));
        chk("t4_c3_ovld",  64'(out_valid),   64'd0);
        tick(); // cycle 4
        bus_data_ok = 1'b1;
        tick(); // cycle 5
        bus_data_ok = 1'b0;
        chk("t4_c5_ovld",  64'(out_valid), 64'd0);
        chk("t4_c5_valid", 64'(ireq.valid), 64'd1);
        chk("t4_c5_addr",  64'(ireq.addr),  64'h0000_0000_8000_0000);
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        tick(); // cycle 6
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        chk("t4_c6_ovld", 64'(out_valid), 64'd1);
        chk("t4_c6_pc",   64'(out_pc),    64'h0000_0000_8000_0000);
        chk("t4_c6_inst", 64'(out_inst),  64'h0000_0000_7fff_ffff);
        chk("t4_c6_addr", 64'(ireq.addr), 64'h0000_0000_8000_0004);

        // ---- Redirect coinciding with data_ok and a pop, count=2
        do_reset();
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        out_ready   = 1'b0;
        tick(); // cycle 1
        tick(); // cycle 2
        chk("t5_c2_count", 64'(dut.count_q), 64'd1);
        tick(); // cycle 3
        chk("t5_c3_count", 64'(dut.count_q), 64'd2);
        chk("t5_c3_addr",  64'(ireq.addr),   64'h0000_0000_bfc0_0008);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        out_ready      = 1'b1;
        tick(); // cycle 4
        redirect_valid = 1'b0;
        bus_addr_ok    = 1'b0;
        bus_data_ok    = 1'b0;
        chk("t5_c4_count", 64'(dut.count_q), 64'd0);
        chk("t5_c4_ovld",  64'(out_valid),   64'd0);
        chk("t5_c4_state", 64'(dut.state_q), 64'(S_IDLE));
        chk("t5_c4_valid", 64'(ireq.valid),  64'd0);
        tick(); // cycle 5
        chk("t5_c5_valid", 64'(ireq.valid), 64'd1);
        chk("t5_c5_addr",  64'(ireq.addr),  64'h0000_0000_0000_1002);
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        tick(); // cycle 6
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        chk("t5_c6_pc",   64'(out_pc),   64'h0000_0000_0000_1002);
        chk("t5_c6_inst", 64'(out_inst), 64'h0000_0000_ffff_effd);

        // ---- Asynchronous reset in the middle of WAIT
        do_reset();
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        out_ready   = 1'b0;
        tick(); // cycle 1
        tick(); // cycle 2
        bus_data_ok = 1'b0;
        tick(); // cycle 3
        bus_addr_ok = 1'b0;
        chk("t6_pre_state", 64'(dut.state_q), 64'(S_WAIT));
        chk("t6_pre_ovld",  64'(out_valid),   64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_async_ovld",  64'(out_valid),  64'd0);
        chk("t6_async_pc",    64'(out_pc),     64'd0);
        chk("t6_async_inst",  64'(out_inst),   64'd0);
        chk("t6_async_valid", 64'(ireq.valid), 64'd0);
        chk("t6_async_addr",  64'(ireq.addr),  64'(RST_PC));
        do_reset();
        tick(); // cycle 1
        chk("t6_restart_valid", 64'(ireq.valid), 64'd1);
        chk("t6_restart_addr",  64'(ireq.addr),  64'(RST_PC));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
